// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: turns one pipeline memory access into a
// req/ack bus transaction, stalling the pipeline until it completes or times out.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  count;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [1:0]  lat_lane;

  logic        issue;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Size code 11 behaves exactly like a word access.
  assign addr_err = mem_en & (((mem_size == 2'b01) & addr[0]) |
                              (mem_size[1] & (addr[1:0] != 2'b00)));

  assign issue       = (state == IDLE) & mem_en & ~addr_err;
  assign timeout_hit = (state == ACCESS) & ~bus_ack & (count == LAST_COUNT);
  assign stall       = issue | (state == ACCESS);
  assign bus_req     = (state == ACCESS);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = ACCESS;
      ACCESS:  if (bus_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mem_size)
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  // Extraction works only from the latched copies so upstream changes during ACCESS are harmless.
  always_comb begin
    lane_byte = bus_rdata[7:0];
    case (lat_lane)
      2'd0: lane_byte = bus_rdata[7:0];
      2'd1: lane_byte = bus_rdata[15:8];
      2'd2: lane_byte = bus_rdata[23:16];
      2'd3: lane_byte = bus_rdata[31:24];
      default: lane_byte = bus_rdata[7:0];
    endcase
    lane_half = lat_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b00:   load_ext = {{24{lat_sign & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{lat_sign & lane_half[15]}}, lane_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_lane  <= 2'b00;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state   <= state_next;
      bus_err <= timeout_hit;
      if (issue) begin
        lat_wr    <= mem_wr;
        lat_size  <= mem_size;
        lat_sign  <= mem_sign;
        lat_lane  <= addr[1:0];
        bus_we    <= mem_wr;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_next;
        bus_wdata <= wdata_next;
      end
      if (state == ACCESS) begin
        if (bus_ack) begin
          if (!lat_wr) rdata <= load_ext;
        end else begin
          count <= count + 8'd1;
          if (timeout_hit) rdata <= 32'd0;
        end
      end else begin
        count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scoreboard of expected bus fields and
// load results per access, with a cycle-level bus responder inside the access task.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_sign = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  logic [31:0] model_rdata = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sign(mem_sign), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sign,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] brd, input bit timeout);
    exp_t e;
    logic [31:0] shifted;
    e.addr = a & 32'hFFFF_FFFC;
    e.we   = wr;
    e.err  = timeout;
    if (size == 2'b00) begin
      case (a[1:0])
        2'd0: e.be = 4'b0001;
        2'd1: e.be = 4'b0010;
        2'd2: e.be = 4'b0100;
        default: e.be = 4'b1000;
      endcase
      e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      shifted = brd >> (8 * a[1:0]);
      e.rdata = (sign && shifted[7]) ? (shifted | 32'hFFFF_FF00) : (shifted & 32'h0000_00FF);
    end else if (size == 2'b01) begin
      e.be    = a[1] ? 4'b1100 : 4'b0011;
      e.wdata = {wd[15:0], wd[15:0]};
      shifted = a[1] ? (brd >> 16) : brd;
      e.rdata = (sign && shifted[15]) ? (shifted | 32'hFFFF_0000) : (shifted & 32'h0000_FFFF);
    end else begin
      e.be    = 4'b1111;
      e.wdata = wd;
      e.rdata = brd;
    end
    if (wr) e.rdata = model_rdata;
    if (timeout) e.rdata = 32'd0;
    return e;
  endfunction

  // Caller must be just after a posedge (or at a DONE negedge); the first negedge seen is the issue cycle.
  task automatic apply_stimulus(input string name, input logic wr, input logic [1:0] size,
                                input logic sign, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] brd, input int waits, input bit scramble,
                                output int stall_cycles, output int req_cycles, output int first_req);
    exp_t e;
    exp_t got;
    bit done;
    mem_en = 1'b1; mem_wr = wr; mem_size = size; mem_sign = sign; addr = a; wdata = wd;
    bus_ack = 1'b0;
    e = model(wr, size, sign, a, wd, brd, waits < 0);
    sb.push_back(e);
    stall_cycles = 0; req_cycles = 0; first_req = -1; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (stall) stall_cycles++;
      if (bus_req) begin
        if (first_req < 0) first_req = cyc;
        req_cycles++;
        check_output({name, "_bus_addr"}, bus_addr, e.addr);
        check_output({name, "_bus_be"}, {28'd0, bus_be}, {28'd0, e.be});
        check_output({name, "_bus_wdata"}, bus_wdata, e.wdata);
        check_output({name, "_bus_we"}, {31'd0, bus_we}, {31'd0, e.we});
        if (scramble) begin
          addr  = a ^ 32'h5A5A_5A57;
          wdata = wd ^ 32'hFFFF_FFFF;
        end
        bus_ack   = (waits >= 0) && (req_cycles == waits + 1);
        bus_rdata = bus_ack ? brd : 32'hDEAD_BEEF;
      end else begin
        bus_ack = 1'b0;
        if (req_cycles > 0) begin
          got = sb.pop_front();
          check_output({name, "_done_stall"}, {31'd0, stall}, 32'd0);
          check_output({name, "_bus_err"}, {31'd0, bus_err}, {31'd0, got.err});
          check_output({name, "_rdata"}, rdata, got.rdata);
          model_rdata = got.rdata;
          done = 1;
        end
      end
    end
    check_output({name, "_completed"}, {31'd0, done}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    mem_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc, rc, fr;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_output("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_output("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check_output("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check_output("rst_rdata", rdata, 32'd0);
    check_output("rst_bus_addr", bus_addr, 32'd0);
    check_output("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check_output("rst_bus_wdata", bus_wdata, 32'd0);
    check_output("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);

    $display("[TB] zero-wait signed byte load");
    apply_stimulus("ldb", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0, sc, rc, fr);
    check_output("ldb_stall_cycles", sc, 2);
    check_output("ldb_req_cycles", rc, 1);
    idle_cycles(1);

    $display("[TB] half store with three wait cycles");
    apply_stimulus("sth", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 3, 0, sc, rc, fr);
    check_output("sth_stall_cycles", sc, 5);
    check_output("sth_req_cycles", rc, 4);

    $display("[TB] misaligned accesses");
    mem_en = 1'b1; mem_wr = 1'b1; mem_size = 2'b01; addr = 32'h0000_2001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("mis_half_addr_err", {31'd0, addr_err}, 32'd1);
      check_output("mis_half_stall", {31'd0, stall}, 32'd0);
      check_output("mis_half_bus_req", {31'd0, bus_req}, 32'd0);
    end
    mem_size = 2'b11; addr = 32'h0000_2002; #1;
    check_output("mis_word_addr_err", {31'd0, addr_err}, 32'd1);
    mem_size = 2'b00; addr = 32'h0000_2003; #1;
    check_output("byte_odd_addr_err", {31'd0, addr_err}, 32'd0);
    mem_en = 1'b0; mem_size = 2'b10; addr = 32'h0000_2001; #1;
    check_output("mis_disabled_addr_err", {31'd0, addr_err}, 32'd0);
    idle_cycles(1);

    $display("[TB] unsigned half load with input scrambling");
    apply_stimulus("ldhu", 1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h1357_9BDF, 32'h1234_8001, 1, 1, sc, rc, fr);
    check_output("ldhu_stall_cycles", sc, 3);
    idle_cycles(1);

    $display("[TB] back-to-back word store then word load");
    apply_stimulus("b2b_st", 1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h1122_3344, 32'hFFFF_FFFF, 0, 0, sc, rc, fr);
    apply_stimulus("b2b_ld", 1'b0, 2'b10, 1'b1, 32'h0000_3004, 32'd0, 32'hCAFE_F00D, 0, 0, sc, rc, fr);
    check_output("b2b_first_req", fr, 1);
    check_output("b2b_req_cycles", rc, 1);
    idle_cycles(1);

    $display("[TB] timeout abort");
    apply_stimulus("tmo", 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, 32'h0, -1, 0, sc, rc, fr);
    check_output("tmo_req_cycles", rc, 4);
    check_output("tmo_stall_cycles", sc, 5);
    mem_en = 1'b0;
    @(negedge clk);
    check_output("tmo_err_pulse_end", {31'd0, bus_err}, 32'd0);
    idle_cycles(1);

    apply_stimulus("ldw", 1'b0, 2'b11, 1'b1, 32'h0000_6000, 32'd0, 32'h8765_4321, 0, 0, sc, rc, fr);
    idle_cycles(1);

    $display("[TB] reset during ACCESS");
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; addr = 32'h0000_4000;
    @(negedge clk);
    check_output("rstacc_issue_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check_output("rstacc_bus_req_before", {31'd0, bus_req}, 32'd1);
    mem_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_output("rstacc_bus_req", {31'd0, bus_req}, 32'd0);
    check_output("rstacc_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("rstacc_stall_after", {31'd0, stall}, 32'd0);
    check_output("rstacc_bus_req_after", {31'd0, bus_req}, 32'd0);

    check_output("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller between the pipelined datapath and a variable-latency data bus.
- Consumes the MEM-stage access request: address, store data, size, sign and write flag.
- Generates byte enables, lane-replicated store data and a req/ack bus handshake, and returns sign- or zero-extended load data.
- Stalls the pipeline until each access completes; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles `bus_req` stays high without `bus_ack` before the access is aborted; range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_en  in  1  valid load/store in MEM stage
- mem_wr  in  1  1=store, 0=load
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_sign  in  1  1=sign-extend load, 0=zero-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-justified
- rdata  out  32  extended load result, registered
- stall  out  1  hold IF..MEM pipeline registers
- addr_err  out  1  misaligned access, combinational
- bus_err  out  1  one-cycle pulse on timeout abort
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_be  out  4  byte enables; bit i = byte lane i, little-endian
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete; `bus_rdata` valid on loads
- bus_rdata  in  32  raw word from bus

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - `bus_req`, `bus_we`, `bus_err`, `rdata`, `bus_addr`, `bus_be` and `bus_wdata` all 0.
  - Timeout counter=0.
  - An outstanding access is abandoned; `bus_req` drops in the same cycle.
- Misalignment:
  - `addr_err` = mem_en & ((size=half & addr[0]) | (size∈{word,11} & addr[1:0]≠0)).
  - A misaligned access issues no bus request and asserts no `stall`; state stays IDLE.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if mem_en & ~addr_err, latch `mem_wr`, `mem_size`, `mem_sign`, `addr` and `wdata` into internal registers. Go to ACCESS; `bus_req`=1 from the next cycle.
  - ACCESS: `bus_req`=1; bus outputs driven only from the latched copies and held stable until ack. Upstream input changes are ignored.
    - On `bus_ack`=1: loads capture the extended `bus_rdata` into `rdata`; stores leave `rdata` unchanged. Go to DONE.
    - Else the timeout counter increments. When counter=TIMEOUT-1 with no ack: go to DONE, `rdata`=0, `bus_err`=1 for one cycle (the DONE cycle).
  - DONE: `bus_req`=0, `stall`=0; pipeline advances at this edge. Unconditionally go to IDLE; counter cleared.
- stall = (IDLE & mem_en & ~addr_err) | ACCESS.
- Minimum latency: issue cycle, ACCESS cycle with ack, DONE cycle, i.e. 2 stall cycles per access.
- Back-to-back accesses: the next instruction enters MEM at the DONE edge and is evaluated in IDLE.
- `bus_ack` is ignored outside ACCESS.
- `bus_addr`, `bus_be`, `bus_wdata` and `bus_we` are meaningful only while `bus_req`=1; they are registered from the latched copies.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Loads use the same `bus_be`.
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte: lane addr[1:0] → bits [8k+7:8k], extended from bit 7.
  - half: addr[1] selects [31:16] or [15:0], extended from bit 15.
  - word: passthrough; `mem_sign` ignored.
- Extension uses `mem_sign`: sign-extend when 1, zero-extend when 0.
- `rdata` holds its value until the next completed load or timeout.

Test Plan:
- Reset mid-ACCESS: assert `rst` while `bus_req`=1 → `bus_req`=0 and `rdata`=0 in the same cycle; state IDLE; `stall`=0 after release.
- Zero-wait byte load: addr=0x1003, mem_sign=1, `bus_ack` high in the first req cycle, `bus_rdata`=0x80FF_1234 → `bus_be`=1000, `bus_addr`=0x1000, `stall` high 2 cycles, `rdata`=0xFFFF_FF80.
- Half stores: addr=0x2002, wdata=0x0000_ABCD, ack after 3 wait cycles → `bus_be`=1100, `bus_wdata`=0xABCD_ABCD, `bus_we`=1 held stable for 4 req cycles, `stall` 5 cycles. Then addr=0x2001 → `addr_err`=1, `bus_req` never asserted, `stall`=0.
- Unsigned half load: addr=0x0, mem_sign=0, `bus_rdata`=0x1234_8001 → `rdata`=0x0000_8001. Changing `addr`/`wdata` inputs during ACCESS does not alter `bus_addr`/`bus_wdata`.
- Timeout with TIMEOUT=4: load with no ack → `bus_req` high exactly 4 cycles, `bus_err` 1-cycle pulse in DONE, `rdata`=0, `stall` low in DONE.
- Back-to-back: word store followed by word load, ack immediate each time → second `bus_req` rises the cycle after the first DONE; no ack from the first access is reused.
